mynios2_multi_timer: RTL and testbench

MYNIOS2_MULTI_TIMER -- requirements
Module: mynios2_multi_timer

---
 rtl/mynios2_multi_timer_if.sv | 22 ++
 rtl/mynios2_multi_timer.sv | 207 ++++++++++++++++++++
 tb/tb_mynios2_multi_timer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mynios2_multi_timer_if.sv
// Avalon-MM slave bus and interrupt lines of the multi-channel timer.
interface mynios2_multi_timer_if #(
  parameter int NUM_CH = 4
);
  logic [4:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq, irq_any
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq, irq_any
  );
endinterface

// File: rtl/mynios2_multi_timer.sv
// Multi-channel interval timer behind an Avalon-MM register slave.
// Each channel has a prescaled down-counter (periodic or one-shot), a sticky
// timeout flag with interrupt enable, and a counter snapshot register.
// Register map per channel: 0 STATUS, 1 CONTROL, 2 PERIOD, 3 SNAPSHOT, 4 COUNT.
module mynios2_multi_timer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 49999
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mynios2_multi_timer_if.slave bus
);

  localparam logic [2:0]       REG_STATUS   = 3'd0;
  localparam logic [2:0]       REG_CONTROL  = 3'd1;
  localparam logic [2:0]       REG_PERIOD   = 3'd2;
  localparam logic [2:0]       REG_SNAPSHOT = 3'd3;
  localparam logic [2:0]       REG_COUNT    = 3'd4;
  localparam logic [CNT_W-1:0] RST_VAL      = CNT_W'(RST_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        addr_ch_s;
  logic [2:0]        addr_reg_s;
  logic              ch_ok_s;
  logic              wr_s;
  logic              unused_wd_s;
  logic [NUM_CH-1:0] wr_status_s, wr_ctrl_s, wr_period_s, wr_snap_s;
  logic [NUM_CH-1:0] start_s, stop_s, tick_s, zero_s, event_s, oneshot_end_s;
  logic [31:0]       rd_ch_s [NUM_CH];

  logic [NUM_CH-1:0] to_q, to_d, run_q, run_d, ito_q, ito_d, cont_q, cont_d;
  logic [NUM_CH-1:0] force_q, force_d, zero_prev_q, zero_prev_d;
  logic [7:0]        presc_q  [NUM_CH];
  logic [7:0]        presc_d  [NUM_CH];
  logic [7:0]        pre_q    [NUM_CH];
  logic [7:0]        pre_d    [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  snap_q   [NUM_CH];
  logic [CNT_W-1:0]  snap_d   [NUM_CH];
  logic [31:0]       rdata_q, rdata_d;

  assign addr_ch_s   = bus.address[4:3];
  assign addr_reg_s  = bus.address[2:0];
  assign ch_ok_s     = ({1'b0, addr_ch_s} < 3'(NUM_CH));
  assign wr_s        = bus.chipselect && !bus.write_n && ch_ok_s && (addr_reg_s <= REG_SNAPSHOT);
  // Only some writedata bits are meaningful; fold the rest so they are consumed.
  assign unused_wd_s = ^bus.writedata;

  // Per-channel write strobes and counter condition flags.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      wr_status_s[n]   = wr_s && (addr_ch_s == 2'(n)) && (addr_reg_s == REG_STATUS);
      wr_ctrl_s[n]     = wr_s && (addr_ch_s == 2'(n)) && (addr_reg_s == REG_CONTROL);
      wr_period_s[n]   = wr_s && (addr_ch_s == 2'(n)) && (addr_reg_s == REG_PERIOD);
      wr_snap_s[n]     = wr_s && (addr_ch_s == 2'(n)) && (addr_reg_s == REG_SNAPSHOT);
      start_s[n]       = wr_s && (addr_ch_s == 2'(n)) && (addr_reg_s == REG_CONTROL) && bus.writedata[2];
      stop_s[n]        = wr_s && (addr_ch_s == 2'(n)) && (addr_reg_s == REG_CONTROL) && bus.writedata[3];
      zero_s[n]        = (cnt_q[n] == CNT_ZERO);
      tick_s[n]        = run_q[n] && (pre_q[n] == 8'd0);
      // Timeout is the rising edge of the zero flag, so a counter parked at 0 never retriggers.
      event_s[n]       = zero_s[n] && !zero_prev_q[n];
      // One-shot mode stops on the tick that lands on (or already sits at) zero.
      oneshot_end_s[n] = tick_s[n] && !cont_q[n] && (zero_s[n] || (cnt_q[n] == CNT_ONE));
    end
  end

  // Next-state logic for every channel register.
  always_comb begin
    to_d        = to_q;
    run_d       = run_q;
    ito_d       = ito_q;
    cont_d      = cont_q;
    force_d     = wr_period_s;
    zero_prev_d = zero_s;
    presc_d     = presc_q;
    pre_d       = pre_q;
    period_d    = period_q;
    cnt_d       = cnt_q;
    snap_d      = snap_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (wr_ctrl_s[n]) begin
        ito_d[n]   = bus.writedata[0];
        cont_d[n]  = bus.writedata[1];
        presc_d[n] = bus.writedata[15:8];
      end else begin
        ito_d[n]   = ito_q[n];
        cont_d[n]  = cont_q[n];
        presc_d[n] = presc_q[n];
      end

      if (wr_period_s[n]) begin
        period_d[n] = bus.writedata[CNT_W-1:0];
      end else begin
        period_d[n] = period_q[n];
      end

      if (wr_snap_s[n]) begin
        snap_d[n] = cnt_q[n];
      end else begin
        snap_d[n] = snap_q[n];
      end

      // A pending force_reload overrides any tick in the same cycle.
      if (force_q[n]) begin
        cnt_d[n] = period_q[n];
      end else if (tick_s[n] && zero_s[n] && cont_q[n]) begin
        cnt_d[n] = period_q[n];
      end else if (tick_s[n] && !zero_s[n]) begin
        cnt_d[n] = cnt_q[n] - CNT_ONE;
      end else begin
        cnt_d[n] = cnt_q[n];
      end

      // START beats STOP, force_reload and the one-shot stop.
      if (start_s[n]) begin
        run_d[n] = 1'b1;
      end else if (force_q[n] || stop_s[n] || oneshot_end_s[n]) begin
        run_d[n] = 1'b0;
      end else begin
        run_d[n] = run_q[n];
      end

      // Reload uses the PRESC in effect after this cycle's CONTROL write.
      if (start_s[n] || force_q[n] || tick_s[n]) begin
        pre_d[n] = presc_d[n];
      end else if (run_q[n]) begin
        pre_d[n] = pre_q[n] - 8'd1;
      end else begin
        pre_d[n] = pre_q[n];
      end

      // A timeout coinciding with a STATUS write must not be lost.
      if (event_s[n]) begin
        to_d[n] = 1'b1;
      end else if (wr_status_s[n]) begin
        to_d[n] = 1'b0;
      end else begin
        to_d[n] = to_q[n];
      end
    end
  end

  // Per-channel read view of the addressed register.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      case (addr_reg_s)
        REG_STATUS:   rd_ch_s[n] = {30'd0, run_q[n], to_q[n]};
        REG_CONTROL:  rd_ch_s[n] = {16'd0, presc_q[n], 6'd0, cont_q[n], ito_q[n]};
        REG_PERIOD:   rd_ch_s[n] = 32'(period_q[n]);
        REG_SNAPSHOT: rd_ch_s[n] = 32'(snap_q[n]);
        REG_COUNT:    rd_ch_s[n] = 32'(cnt_q[n]);
        default:      rd_ch_s[n] = 32'd0;
      endcase
    end
  end

  // Channel select for read data; channels beyond NUM_CH never match and read 0.
  always_comb begin
    rdata_d = 32'd0;
    for (int n = 0; n < NUM_CH; n++) begin
      rdata_d = rdata_d | ((addr_ch_s == 2'(n)) ? rd_ch_s[n] : 32'd0);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q        <= {NUM_CH{1'b0}};
      run_q       <= {NUM_CH{1'b0}};
      ito_q       <= {NUM_CH{1'b0}};
      cont_q      <= {NUM_CH{1'b0}};
      force_q     <= {NUM_CH{1'b0}};
      zero_prev_q <= {NUM_CH{(RST_VAL == CNT_ZERO)}};
      rdata_q     <= 32'd0;
      for (int n = 0; n < NUM_CH; n++) begin
        presc_q[n]  <= 8'd0;
        pre_q[n]    <= 8'd0;
        period_q[n] <= RST_VAL;
        cnt_q[n]    <= RST_VAL;
        snap_q[n]   <= CNT_ZERO;
      end
    end else begin
      to_q        <= to_d;
      run_q       <= run_d;
      ito_q       <= ito_d;
      cont_q      <= cont_d;
      force_q     <= force_d;
      zero_prev_q <= zero_prev_d;
      rdata_q     <= rdata_d;
      presc_q     <= presc_d;
      pre_q       <= pre_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign bus.irq      = to_q & ito_q;
  assign bus.irq_any  = |(to_q & ito_q);

endmodule

// File: tb/tb_mynios2_multi_timer.sv
// Self-checking bench for mynios2_multi_timer: directed scenarios plus random
// bus traffic, compared every cycle against a behavioural channel model.
module tb_mynios2_multi_timer;

  localparam int NUM_CH     = 2;
  localparam int CNT_W      = 16;
  localparam int RST_PERIOD = 49;
  localparam int CNT_MASK   = (1 << CNT_W) - 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  mynios2_multi_timer_if #(.NUM_CH(NUM_CH)) bus ();

  mynios2_multi_timer #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .RST_PERIOD(RST_PERIOD)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural model: prescaler kept as "clocks since last reload" against the
  // divisor captured at that reload; counter as a plain integer.
  bit m_to        [NUM_CH];
  bit m_run       [NUM_CH];
  bit m_ito       [NUM_CH];
  bit m_cont      [NUM_CH];
  bit m_prev_zero [NUM_CH];
  bit m_force     [NUM_CH];
  int m_presc     [NUM_CH];
  int m_period    [NUM_CH];
  int m_cnt       [NUM_CH];
  int m_snap      [NUM_CH];
  int m_phase     [NUM_CH];
  int m_pdiv      [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      m_to[n] = 1'b0; m_run[n] = 1'b0; m_ito[n] = 1'b0; m_cont[n] = 1'b0;
      m_force[n] = 1'b0; m_presc[n] = 0; m_phase[n] = 0; m_pdiv[n] = 0;
      m_period[n] = RST_PERIOD; m_cnt[n] = RST_PERIOD; m_snap[n] = 0;
      m_prev_zero[n] = (RST_PERIOD == 0);
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    int ch;
    int r;
    ch = int'(a[4:3]);
    r  = int'(a[2:0]);
    if (ch >= NUM_CH) return 32'd0;
    case (r)
      0: return {30'd0, m_run[ch], m_to[ch]};
      1: return (32'(m_presc[ch]) << 8) | (32'(m_cont[ch]) << 1) | 32'(m_ito[ch]);
      2: return 32'(m_period[ch]);
      3: return 32'(m_snap[ch]);
      4: return 32'(m_cnt[ch]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit event_pending(input int n);
    return (m_cnt[n] == 0) && !m_prev_zero[n];
  endfunction

  function automatic void model_step(input logic [4:0] a, input logic cs, input logic wn,
                                     input logic [31:0] wd);
    int ch;
    int r;
    bit wr, sel, start, stop, ev, tick, run_next;
    int cnt_next;
    ch = int'(a[4:3]);
    r  = int'(a[2:0]);
    wr = cs && !wn && (ch < NUM_CH) && (r <= 3);
    for (int n = 0; n < NUM_CH; n++) begin
      sel   = wr && (ch == n);
      start = sel && (r == 1) && wd[2];
      stop  = sel && (r == 1) && wd[3];
      ev    = event_pending(n);
      tick  = m_run[n] && (m_phase[n] == m_pdiv[n]);
      run_next = m_run[n];
      cnt_next = m_cnt[n];
      if (tick) begin
        cnt_next = (m_cnt[n] == 0) ? (m_cont[n] ? m_period[n] : 0) : m_cnt[n] - 1;
        if (!m_cont[n] && cnt_next == 0) run_next = 1'b0;
      end
      if (m_force[n]) begin
        cnt_next = m_period[n];
        run_next = 1'b0;
      end
      if (stop)  run_next = 1'b0;
      if (start) run_next = 1'b1;
      if (sel && r == 1) begin
        m_ito[n]   = wd[0];
        m_cont[n]  = wd[1];
        m_presc[n] = int'(wd[15:8]);
      end
      if (start || m_force[n] || tick) begin
        m_phase[n] = 0;
        m_pdiv[n]  = m_presc[n];
      end else if (m_run[n]) begin
        m_phase[n] = m_phase[n] + 1;
      end
      if (sel && r == 3) m_snap[n] = m_cnt[n];
      if (ev) m_to[n] = 1'b1;
      else if (sel && r == 0) m_to[n] = 1'b0;
      m_prev_zero[n] = (m_cnt[n] == 0);
      m_force[n]     = sel && (r == 2);
      if (sel && r == 2) m_period[n] = int'(wd) & CNT_MASK;
      m_run[n] = run_next;
      m_cnt[n] = cnt_next;
    end
  endfunction

  // One bus cycle: drive, advance the model, clock, then compare all outputs.
  task automatic cycle(input logic [4:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    logic [31:0]       exp_rd;
    logic [NUM_CH-1:0] exp_irq;
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wd;
    if (!reset_n) begin
      exp_rd = 32'd0;
      model_reset();
    end else begin
      exp_rd = model_read(a);
      model_step(a, cs, wn, wd);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < NUM_CH; n++) exp_irq[n] = m_to[n] && m_ito[n];
    chk("readdata", bus.readdata, exp_rd);
    chk("irq", 32'(bus.irq), 32'(exp_irq));
    chk("irq_any", 32'(bus.irq_any), 32'(|exp_irq));
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    cycle({2'(ch), 3'(r)}, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input int ch, input int r);
    cycle({2'(ch), 3'(r)}, 1'b1, 1'b1, 32'd0);
  endtask

  // Idles (reading COUNT) until irq[n] is seen; returns the cycle number or -1.
  task automatic wait_irq(input int n, input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      rd(n, 4);
      if (bus.irq[n] === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk($sformatf("wait_irq%0d_seen", n), 32'(at >= 0), 32'd1);
  endtask

  initial begin
    int t0, t1, t2;
    bit found;
    logic [4:0]  ra;
    logic        rcs, rwn;
    logic [31:0] rwd;

    // Reset: outputs held at zero.
    for (int i = 0; i < 3; i++) rd(0, 0);
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_irq_any", 32'(bus.irq_any), 32'd0);
    reset_n = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int r = 0; r < 5; r++) rd(ch, r);

    // ch0 periodic from reset PERIOD: first timeout PERIOD+1 clocks after START, then every PERIOD+1.
    wr(0, 1, 32'h7);
    t0 = cyc;
    wait_irq(0, 200, t1);
    chk("ch0_first_to", 32'(t1 - t0), 32'(RST_PERIOD + 1));
    wr(0, 0, 32'h0);
    wait_irq(0, 200, t2);
    chk("ch0_period", 32'(t2 - t1), 32'(RST_PERIOD + 1));

    // ch1 one-shot: PERIOD 9, PRESC 3, START coinciding with force_reload.
    wr(1, 2, 32'd9);
    wr(1, 1, 32'h0305);
    wait_irq(1, 100, t1);
    for (int i = 0; i < 10; i++) rd(1, 4);
    rd(1, 0);
    chk("ch1_oneshot_run", 32'(bus.readdata[1]), 32'd0);
    rd(1, 4);
    chk("ch1_oneshot_count", bus.readdata, 32'd0);
    wr(1, 0, 32'h0);
    for (int i = 0; i < 30; i++) rd(1, 4);
    chk("ch1_no_retrigger", 32'(bus.irq[1]), 32'd0);

    // STATUS write on the very cycle of a timeout keeps TO set.
    wr(0, 2, 32'd5);
    wr(0, 1, 32'h7);
    wait_irq(0, 50, t1);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (event_pending(0)) begin
        wr(0, 0, 32'h0);
        found = 1'b1;
        break;
      end
      rd(0, 4);
    end
    chk("coincident_found", 32'(found), 32'd1);
    chk("coincident_to_kept", 32'(bus.irq[0]), 32'd1);

    // PERIOD write while running: RUN drops, COUNT takes the new PERIOD, START restarts there.
    wr(0, 2, 32'd20);
    rd(0, 0);
    rd(0, 0);
    chk("reload_run_cleared", 32'(bus.readdata[1]), 32'd0);
    rd(0, 4);
    chk("reload_count", bus.readdata, 32'd20);
    wr(0, 1, 32'h7);
    rd(0, 4);
    chk("restart_count0", bus.readdata, 32'd20);
    rd(0, 4);
    chk("restart_count1", bus.readdata, 32'd19);

    // START and STOP together: START wins. Then snapshot mid-count.
    wr(1, 1, 32'hE);
    rd(1, 0);
    chk("start_stop_run", 32'(bus.readdata[1]), 32'd1);
    for (int i = 0; i < 4; i++) rd(1, 4);
    wr(1, 3, 32'h0);
    rd(1, 3);
    rd(1, 4);

    // Channel beyond NUM_CH and unused register slots.
    wr(3, 2, 32'h1234);
    wr(2, 1, 32'h7);
    rd(3, 2);
    chk("ch3_read_zero", bus.readdata, 32'd0);
    rd(0, 5);
    rd(0, 7);
    chk("reg7_read_zero", bus.readdata, 32'd0);
    wr(0, 4, 32'h55);
    rd(0, 2);
    rd(1, 2);

    // Random traffic with small periods/prescalers so events are frequent.
    for (int i = 0; i < 600; i++) begin
      ra  = 5'($urandom_range(0, 31));
      rcs = ($urandom_range(0, 3) != 0);
      rwn = ($urandom_range(0, 2) != 0);
      rwd = $urandom;
      if (ra[2:0] == 3'd2) rwd = 32'($urandom_range(0, 12));
      if (ra[2:0] == 3'd1) rwd = rwd & 32'h0000_030F;
      cycle(ra, rcs, rwn, rwd);
    end

    // Reset asserted mid-count aborts at once; channel stays idle afterwards.
    wr(0, 2, 32'd30);
    wr(0, 1, 32'h7);
    for (int i = 0; i < 3; i++) rd(0, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", bus.readdata, 32'd0);
    chk("async_rst_irq", 32'(bus.irq), 32'd0);
    model_reset();
    rd(0, 0);
    rd(0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) rd(0, 0);
    chk("post_rst_idle", 32'(bus.readdata[1]), 32'd0);
    rd(0, 4);
    chk("post_rst_count", bus.readdata, 32'(RST_PERIOD));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
